// File: rtl/ahb_lite_slave_sram.sv
// AHB-Lite word-memory slave with byte/half/word writes, optional wait states and a two-cycle ERROR response.
// Latency: the data phase takes 1 cycle, or WAIT_STATES+1 cycles; an ERROR always takes 2 cycles.
// Backpressure: HREADY is decoded from registered state; the address phase is sampled only while HREADY=1.
module ahb_lite_slave_sram #(
    parameter logic [31:0] ADDR_BASE   = 32'h0000_0000,
    parameter int          DEPTH_WORDS = 64,
    parameter int          WAIT_STATES = 0,
    localparam int         IW          = $clog2(DEPTH_WORDS)
) (
    input  logic          HCLK,
    input  logic          HRESET,
    input  logic          HSEL,
    input  logic [31:0]   HADDR,
    input  logic          HWRITE,
    input  logic [2:0]    HSIZE,
    input  logic [2:0]    HBURST,
    input  logic [1:0]    HTRANS,
    input  logic [31:0]   HWDATA,
    output logic          HREADY,
    output logic          HRESP,
    output logic [31:0]   HRDATA,
    input  logic [IW-1:0] dbg_addr,
    output logic [31:0]   dbg_rdata
);

    localparam logic [31:0] SPAN = 32'(4 * DEPTH_WORDS);
    localparam logic [2:0]  WS   = 3'(WAIT_STATES);

    typedef enum logic [1:0] {ST_READY, ST_STALL, ST_ERR1, ST_ERR2} state_t;

    state_t      r_state, w_state_nxt;
    logic [2:0]  r_cnt, w_cnt_nxt;

    logic           r_dp_valid;
    logic           r_dp_write;
    logic           r_dp_err;
    logic [1:0]     r_dp_size;
    logic [1:0]     r_dp_lane;
    logic [IW-1:0]  r_dp_idx;

    logic [31:0]    r_mem [DEPTH_WORDS];

    logic [31:0]    w_offset;
    logic           w_addr_err;
    logic           w_accept;
    logic           w_dp_done;
    logic [3:0]     w_be;
    logic           w_unused;

    // Bursts are decoded beat by beat, so HBURST and the SEQ/NONSEQ distinction carry no information here.
    assign w_unused = ^{HBURST, HTRANS[0]};

    // An address below the base wraps to a huge offset, so one compare covers both ends of the window.
    assign w_offset   = HADDR - ADDR_BASE;
    assign w_addr_err = (w_offset >= SPAN)
                     || (HSIZE > 3'd2)
                     || ((HSIZE == 3'd1) && HADDR[0])
                     || ((HSIZE == 3'd2) && (HADDR[1:0] != 2'b00));

    assign HREADY    = (r_state == ST_READY) || (r_state == ST_ERR2);
    assign HRESP     = (r_state == ST_ERR1)  || (r_state == ST_ERR2);
    assign w_accept  = HREADY && HSEL && HTRANS[1];
    assign w_dp_done = r_dp_valid && HREADY;

    // The read path is combinational, so a read issued right after a write to the same word returns the new data.
    assign HRDATA    = (r_dp_valid && !r_dp_write && !r_dp_err) ? r_mem[r_dp_idx] : 32'h0;
    assign dbg_rdata = r_mem[dbg_addr];

    // FSM state and wait counter register.
    always_ff @(posedge HCLK) begin
        if (HRESET) begin
            r_state <= ST_READY;
            r_cnt   <= 3'd0;
        end else begin
            r_state <= w_state_nxt;
            r_cnt   <= w_cnt_nxt;
        end
    end

    // Next state: an accept in READY or ERR2 starts either a wait sequence or an error sequence.
    always_comb begin
        w_state_nxt = r_state;
        w_cnt_nxt   = r_cnt;
        case (r_state)
            ST_READY, ST_ERR2: begin
                w_state_nxt = ST_READY;
                if (w_accept) begin
                    if (w_addr_err) begin
                        w_state_nxt = ST_ERR1;
                    end else if (WS != 3'd0) begin
                        w_state_nxt = ST_STALL;
                        w_cnt_nxt   = WS;
                    end
                end
            end
            ST_STALL: begin
                w_cnt_nxt = r_cnt - 3'd1;
                if (r_cnt == 3'd1) begin
                    w_state_nxt = ST_READY;
                end
            end
            ST_ERR1: w_state_nxt = ST_ERR2;
            default: w_state_nxt = ST_READY;
        endcase
    end

    // Latch the address phase. The pending data phase retires when HREADY is seen high without a new accept.
    always_ff @(posedge HCLK) begin
        if (HRESET) begin
            r_dp_valid <= 1'b0;
            r_dp_write <= 1'b0;
            r_dp_err   <= 1'b0;
            r_dp_size  <= 2'd0;
            r_dp_lane  <= 2'd0;
            r_dp_idx   <= '0;
        end else if (w_accept) begin
            r_dp_valid <= 1'b1;
            r_dp_write <= HWRITE;
            r_dp_err   <= w_addr_err;
            r_dp_size  <= HSIZE[1:0];
            r_dp_lane  <= HADDR[1:0];
            r_dp_idx   <= w_offset[IW+1:2];
        end else if (w_dp_done) begin
            r_dp_valid <= 1'b0;
        end
    end

    // Byte-lane enables, little-endian: lane n maps to HWDATA[8n+7:8n].
    always_comb begin
        w_be = 4'b0000;
        case (r_dp_size)
            2'd0:    w_be[r_dp_lane] = 1'b1;
            2'd1:    w_be = r_dp_lane[1] ? 4'b1100 : 4'b0011;
            default: w_be = 4'b1111;
        endcase
    end

    // Memory array. Reset clears every word; a legal write commits at the edge that completes its data phase.
    always_ff @(posedge HCLK) begin
        if (HRESET) begin
            for (int i = 0; i < DEPTH_WORDS; i++) begin
                r_mem[i] <= 32'h0;
            end
        end else if (w_dp_done && r_dp_write && !r_dp_err) begin
            for (int b = 0; b < 4; b++) begin
                if (w_be[b]) begin
                    r_mem[r_dp_idx][8*b +: 8] <= HWDATA[8*b +: 8];
                end
            end
        end
    end

endmodule

// File: tb/tb_ahb_lite_slave_sram.sv
// Bench for ahb_lite_slave_sram: one zero-wait instance and one two-wait-state instance share a bus.
// A driver pushes reference-model expectations into a queue; a monitor pops them when HREADY completes a data phase.
// Stimulus combines directed bus sequences with randomized beats.
module tb_ahb_lite_slave_sram;

    typedef struct {
        logic [31:0] addr;
        logic        wr;
        logic [2:0]  size;
        logic [1:0]  trans;
        logic [2:0]  burst;
        logic [31:0] wdata;
    } beat_t;

    typedef struct {
        logic        resp;
        logic [31:0] rdata;
        int          waits;
    } exp_t;

    logic        clk = 1'b0;
    logic        hreset;
    logic        bus_hsel;
    logic [31:0] haddr;
    logic        hwrite;
    logic [2:0]  hsize;
    logic [2:0]  hburst;
    logic [1:0]  htrans;
    logic [31:0] hwdata;
    logic [5:0]  dbg_addr;
    logic        sel;
    logic        manual;

    logic        hsel0, hsel2;
    logic        hready0, hresp0, hready2, hresp2;
    logic [31:0] hrdata0, hrdata2, dbg0, dbg2;
    logic        hready_a, hresp_a;
    logic [31:0] hrdata_a;

    beat_t       stim_q[$];
    exp_t        exp_q[$];
    logic        cur_xfer;
    logic        dp_active;
    logic [31:0] ref_mem [2][64];

    int n_checks = 0;
    int n_err    = 0;

    always #5 clk = ~clk;

    assign hsel0    = bus_hsel & ~sel;
    assign hsel2    = bus_hsel & sel;
    assign hready_a = sel ? hready2 : hready0;
    assign hresp_a  = sel ? hresp2  : hresp0;
    assign hrdata_a = sel ? hrdata2 : hrdata0;

    ahb_lite_slave_sram #(.ADDR_BASE(32'h0), .DEPTH_WORDS(64), .WAIT_STATES(0)) u0 (
        .HCLK(clk), .HRESET(hreset), .HSEL(hsel0), .HADDR(haddr), .HWRITE(hwrite),
        .HSIZE(hsize), .HBURST(hburst), .HTRANS(htrans), .HWDATA(hwdata),
        .HREADY(hready0), .HRESP(hresp0), .HRDATA(hrdata0),
        .dbg_addr(dbg_addr), .dbg_rdata(dbg0)
    );

    ahb_lite_slave_sram #(.ADDR_BASE(32'h0), .DEPTH_WORDS(64), .WAIT_STATES(2)) u2 (
        .HCLK(clk), .HRESET(hreset), .HSEL(hsel2), .HADDR(haddr), .HWRITE(hwrite),
        .HSIZE(hsize), .HBURST(hburst), .HTRANS(htrans), .HWDATA(hwdata),
        .HREADY(hready2), .HRESP(hresp2), .HRDATA(hrdata2),
        .dbg_addr(dbg_addr), .dbg_rdata(dbg2)
    );

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s (dut %0d): got %h, expected %h", name, sel, act, exp);
        end
    endtask

    // Reference model: AHB byte-addressed rules applied straight to a word array.
    function automatic exp_t model(input logic d, input beat_t b);
        exp_t e;
        int   idx;
        int   lane;
        int   ws;
        ws  = d ? 2 : 0;
        idx = int'(b.addr >> 2);
        if (b.addr >= 32'd256 || b.size > 3'd2 || (b.addr % (32'd1 << b.size)) != 0) begin
            e.resp = 1'b1; e.rdata = 32'h0; e.waits = 1;
        end else if (b.wr) begin
            for (int i = 0; i < (1 << b.size); i++) begin
                lane = int'(b.addr % 4) + i;
                ref_mem[d][idx][8*lane +: 8] = b.wdata[8*lane +: 8];
            end
            e.resp = 1'b0; e.rdata = 32'h0; e.waits = ws;
        end else begin
            e.resp = 1'b0; e.rdata = ref_mem[d][idx]; e.waits = ws;
        end
        return e;
    endfunction

    task automatic push(input logic [31:0] addr, input logic wr, input logic [2:0] size,
                        input logic [1:0] trans, input logic [2:0] burst, input logic [31:0] wdata);
        beat_t b;
        b.addr = addr; b.wr = wr; b.size = size; b.trans = trans; b.burst = burst; b.wdata = wdata;
        stim_q.push_back(b);
    endtask

    task automatic drain(input string name);
        int cyc;
        cyc = 0;
        while ((stim_q.size() != 0 || cur_xfer || dp_active || exp_q.size() != 0) && cyc < 5000) begin
            @(negedge clk);
            cyc++;
        end
        repeat (2) @(negedge clk);
        n_checks++;
        if (cyc >= 5000) begin
            n_err++;
            $display("FAIL %s drain timeout: got %0d cycles, expected under 5000", name, cyc);
        end
    endtask

    task automatic chk_dbg(input string name, input int idx, input logic [31:0] exp);
        dbg_addr = 6'(idx);
        #1;
        chk(name, sel ? dbg2 : dbg0, exp);
    endtask

    // Driver: advances the pipelined address/data phases after every edge that saw HREADY high.
    initial begin
        logic  rdy;
        beat_t cur;
        exp_t  e;
        bus_hsel = 1'b0; haddr = 32'h0; hwrite = 1'b0; hsize = 3'd0; hburst = 3'd0;
        htrans = 2'd0; hwdata = 32'h0; cur_xfer = 1'b0; dp_active = 1'b0;
        forever begin
            @(negedge clk);
            rdy = hready_a;
            @(posedge clk);
            #1;
            if (!manual && !hreset && rdy) begin
                if (cur_xfer) begin
                    e = model(sel, cur);
                    exp_q.push_back(e);
                    hwdata    = cur.wdata;
                    dp_active = 1'b1;
                end else begin
                    dp_active = 1'b0;
                end
                if (stim_q.size() != 0) begin
                    cur      = stim_q.pop_front();
                    bus_hsel = 1'b1;
                    haddr    = cur.addr;
                    hwrite   = cur.wr;
                    hsize    = cur.size;
                    htrans   = cur.trans;
                    hburst   = cur.burst;
                    cur_xfer = cur.trans[1];
                end else begin
                    bus_hsel = 1'b0;
                    htrans   = 2'd0;
                    cur_xfer = 1'b0;
                end
            end
        end
    end

    // Monitor: checks every data phase as it completes, and the response while the slave holds HREADY low.
    initial begin
        int   stalls;
        exp_t e;
        stalls = 0;
        forever begin
            @(negedge clk);
            if (dp_active && !manual) begin
                if (exp_q.size() == 0) begin
                    n_checks++;
                    n_err++;
                    $display("FAIL sb_underflow: got data phase, expected none queued");
                end else if (hready_a) begin
                    e = exp_q.pop_front();
                    chk("hresp", 32'(hresp_a), 32'(e.resp));
                    chk("hrdata", hrdata_a, e.rdata);
                    chk("wait_cycles", 32'(stalls), 32'(e.waits));
                    stalls = 0;
                end else begin
                    stalls++;
                    chk("stall_hresp", 32'(hresp_a), 32'(exp_q[0].resp));
                end
            end
        end
    end

    initial begin
        #400000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int          nz;
        logic [31:0] a;
        logic [2:0]  sz;
        logic [1:0]  tr;
        int          t;
        manual = 1'b0; sel = 1'b0; dbg_addr = 6'd0; hreset = 1'b1;
        for (int d = 0; d < 2; d++)
            for (int i = 0; i < 64; i++) ref_mem[d][i] = 32'h0;

        // Reset.
        @(posedge clk);
        @(negedge clk);
        hreset = 1'b0;
        #1;
        chk("rst_hready0", 32'(hready0), 32'd1);
        chk("rst_hresp0", 32'(hresp0), 32'd0);
        chk("rst_hrdata0", hrdata0, 32'h0);
        chk("rst_hready2", 32'(hready2), 32'd1);
        chk("rst_hresp2", 32'(hresp2), 32'd0);
        nz = 0;
        for (int i = 0; i < 64; i++) begin
            dbg_addr = 6'(i);
            #1;
            if (dbg0 !== 32'h0 || dbg2 !== 32'h0) nz++;
        end
        chk("rst_dbg_nonzero_words", 32'(nz), 32'd0);

        // Write then back-to-back read of the same word.
        push(32'h04, 1'b1, 3'd2, 2'd2, 3'd0, 32'h2A472D4B);
        push(32'h04, 1'b0, 3'd2, 2'd2, 3'd0, 32'h0);
        drain("wr_rd");
        chk_dbg("dbg_word1", 1, 32'h2A472D4B);

        // INCR4 burst.
        push(32'h40, 1'b1, 3'd2, 2'd2, 3'd3, 32'h43264629);
        push(32'h44, 1'b1, 3'd2, 2'd3, 3'd3, 32'h4A404D63);
        push(32'h48, 1'b1, 3'd2, 2'd3, 3'd3, 32'h5166546A);
        push(32'h4C, 1'b1, 3'd2, 2'd3, 3'd3, 32'h576E5A72);
        drain("incr4");
        chk_dbg("dbg_word16", 16, 32'h43264629);
        chk_dbg("dbg_word17", 17, 32'h4A404D63);
        chk_dbg("dbg_word18", 18, 32'h5166546A);
        chk_dbg("dbg_word19", 19, 32'h576E5A72);

        // Byte and half-word lane writes.
        push(32'h05, 1'b1, 3'd0, 2'd2, 3'd0, 32'hA5A5FFA5);
        drain("byte_wr");
        chk_dbg("dbg_byte_wr", 1, 32'h2A47FF4B);
        push(32'h06, 1'b1, 3'd1, 2'd2, 3'd0, 32'hBEEF1234);
        push(32'h04, 1'b0, 3'd2, 2'd2, 3'd0, 32'h0);
        drain("half_wr");
        chk_dbg("dbg_half_wr", 1, 32'hBEEFFF4B);

        // Out-of-range and misaligned accesses return ERROR and write nothing.
        push(32'h100, 1'b1, 3'd2, 2'd2, 3'd0, 32'hDEADBEEF);
        push(32'h02,  1'b1, 3'd2, 2'd2, 3'd0, 32'hDEADBEEF);
        push(32'h04,  1'b0, 3'd2, 2'd2, 3'd0, 32'h0);
        push(32'h100, 1'b0, 3'd2, 2'd2, 3'd0, 32'h0);
        drain("errors");
        chk_dbg("dbg_err_word0", 0, 32'h0);
        chk_dbg("dbg_err_word1", 1, 32'hBEEFFF4B);

        // Two wait states.
        sel = 1'b1;
        push(32'h08, 1'b1, 3'd2, 2'd2, 3'd0, 32'hCAFEF00D);
        push(32'h08, 1'b0, 3'd2, 2'd2, 3'd0, 32'h0);
        drain("ws2");
        chk_dbg("dbg_ws2_word2", 2, 32'hCAFEF00D);

        // Randomized traffic on both instances.
        for (int d = 0; d < 2; d++) begin
            sel = d[0];
            for (int k = 0; k < 150; k++) begin
                a  = ($urandom_range(0, 9) == 0) ? 32'($urandom_range(256, 300)) : 32'($urandom_range(0, 255));
                sz = ($urandom_range(0, 15) == 0) ? 3'd3 : 3'($urandom_range(0, 2));
                if (sz <= 3'd2 && $urandom_range(0, 7) != 0) a = a & ~((32'd1 << sz) - 32'd1);
                t  = int'($urandom_range(0, 7));
                tr = (t == 0) ? 2'd0 : (t == 1) ? 2'd1 : (t < 5) ? 2'd2 : 2'd3;
                push(a, 1'($urandom_range(0, 1)), sz, tr, 3'd1, $urandom());
            end
            drain("random");
        end

        // Whole-memory comparison against the model.
        for (int d = 0; d < 2; d++) begin
            sel = d[0];
            for (int i = 0; i < 64; i++) chk_dbg("final_mem", i, ref_mem[d][i]);
        end

        // Reset during the first stall cycle aborts the write.
        sel = 1'b1;
        manual = 1'b1;
        @(negedge clk);
        bus_hsel = 1'b1; haddr = 32'h08; hwrite = 1'b1; hsize = 3'd2; htrans = 2'd2; hburst = 3'd0;
        @(negedge clk);
        bus_hsel = 1'b0; htrans = 2'd0; hwdata = 32'h13572468;
        chk("abort_stall_hready", 32'(hready2), 32'd0);
        hreset = 1'b1;
        @(negedge clk);
        hreset = 1'b0;
        chk("abort_hready", 32'(hready2), 32'd1);
        chk("abort_hresp", 32'(hresp2), 32'd0);
        repeat (3) @(negedge clk);
        chk_dbg("abort_no_write", 2, 32'h0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_err);
        $finish;
    end

endmodule
